// File: rtl/tsm_kn_pipe.sv
// rtl/tsm_kn_pipe.sv - two-share masked monomial generator with valid/ready pipeline
// Optional TSM_OUT_REG_EN adds a registered output stage (3-cycle latency, 3 in flight).
module tsm_kn_pipe #(
  parameter int K     = 4,
  parameter int M     = 2**K-1,
  parameter int R_W   = K+M,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     inp_share0,
  input  logic [K-1:0]     inp_share1,
  input  logic [R_W-1:0]   PRNG,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     F0,
  output logic [M-1:0]     F1,
  output logic [CNT_W-1:0] out_count
);

  // Bit t-1 is the AND of v[i] over every bit i set in mask t.
  function automatic logic [M-1:0] and_vec(input logic [K-1:0] v);
    logic [M-1:0] r;
    r = '0;
    for (int t = 1; t <= M; t++) r[t-1] = &(v | ~t[K-1:0]);
    return r;
  endfunction

  // XOR over nonempty t within m of A_t & B_(m\t); bx[0] stands for B_0 = 1.
  function automatic logic [M-1:0] cross_terms(input logic [M-1:0] av, input logic [M-1:0] bv);
    logic [M:0]   bx;
    logic [M-1:0] r;
    bx = {bv, 1'b1};
    r  = '0;
    for (int m = 1; m <= M; m++)
      for (int t = 1; t <= M; t++)
        if ((t & ~m) == 0) r[m-1] = r[m-1] ^ (av[t-1] & bx[m & ~t]);
    return r;
  endfunction

  logic             r_s1_valid;
  logic [M-1:0]     r_s1_a;
  logic [K-1:0]     r_s1_b;
  logic [M-1:0]     r_s1_r;
  logic             r_s2_valid;
  logic [M-1:0]     r_f0;
  logic [M-1:0]     r_f1;
  logic [CNT_W-1:0] r_count;

  logic [K-1:0]     w_r_ref;
  logic [M-1:0]     w_r_mono;
  logic [K-1:0]     w_a_ref;
  logic [K-1:0]     w_b_ref;
  logic [M-1:0]     w_b_vec;
  logic [M-1:0]     w_f0_next;
  logic [M-1:0]     w_f1_next;
  logic             w_stall2;
  logic             w_s2_adv;
  logic             w_accept;
  logic             w_xfer;

  assign w_r_ref   = PRNG[R_W-1:M];
  assign w_r_mono  = PRNG[M-1:0];
  assign w_a_ref   = inp_share0 ^ w_r_ref;
  assign w_b_ref   = inp_share1 ^ w_r_ref;
  assign w_b_vec   = and_vec(r_s1_b);
  assign w_f1_next = r_s1_r ^ w_b_vec;
  assign w_f0_next = r_s1_r ^ cross_terms(r_s1_a, w_b_vec);

`ifdef TSM_OUT_REG_EN
  logic         r_s3_valid;
  logic [M-1:0] r_s3_f0;
  logic [M-1:0] r_s3_f1;
  logic         w_s3_adv;

  assign w_s3_adv  = !(r_s3_valid && !out_ready);
  assign w_stall2  = r_s2_valid && !w_s3_adv;
  assign out_valid = r_s3_valid;
  assign F0        = r_s3_f0;
  assign F1        = r_s3_f1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      r_s3_f0    <= '0;
      r_s3_f1    <= '0;
    end else if (w_s3_adv) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_f0 <= r_f0;
        r_s3_f1 <= r_f1;
      end
    end
  end
`else
  assign w_stall2  = r_s2_valid && !out_ready;
  assign out_valid = r_s2_valid;
  assign F0        = r_f0;
  assign F1        = r_f1;
`endif

  assign w_s2_adv  = !w_stall2;
  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  assign in_ready  = !(r_s1_valid && w_stall2);
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = out_valid && out_ready;
  assign out_count = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_r     <= '0;
      r_s2_valid <= 1'b0;
      r_f0       <= '0;
      r_f1       <= '0;
      r_count    <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= and_vec(w_a_ref);
        r_s1_b     <= w_b_ref;
        r_s1_r     <= w_r_mono;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_f0 <= w_f0_next;
          r_f1 <= w_f1_next;
        end
      end
      if (w_xfer) r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tsm_kn_pipe.sv
// tb/tb_tsm_kn_pipe.sv - scoreboard bench for tsm_kn_pipe (K=4) with table vectors and flow corners
module tb_tsm_kn_pipe;
`ifdef TSM_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  a = '0;
  logic [3:0]  b = '0;
  logic [18:0] prng = '0;
  logic        in_ready, out_valid;
  logic [14:0] F0, F1;
  logic [15:0] out_count;
  logic        w_in_ready, w_out_valid;
  logic [14:0] w_f0, w_f1;
  logic [3:0]  w_count;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [18:0] prng;
    logic [14:0] xm;
    logic [14:0] f1;
  } vec_t;

  typedef struct packed {
    logic [14:0] xm;
    logic [14:0] f1;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   checks = 0;
  int   errors = 0;
  logic        prev_stall = 1'b0;
  logic [14:0] prev_f0, prev_f1;

  tsm_kn_pipe #(.K(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inp_share0(a), .inp_share1(b), .PRNG(prng),
    .out_valid(out_valid), .out_ready(out_ready), .F0(F0), .F1(F1), .out_count(out_count)
  );

  tsm_kn_pipe #(.K(4), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .inp_share0(a), .inp_share1(b), .PRNG(prng),
    .out_valid(w_out_valid), .out_ready(out_ready), .F0(w_f0), .F1(w_f1), .out_count(w_count)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] mono(input logic [3:0] x);
    logic [14:0] r;
    for (int m = 1; m <= 15; m++) r[m-1] = ((x & 4'(m)) == 4'(m));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor_cycle();
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_f0", 32'(F0), 32'(prev_f0));
        chk("hold_f1", 32'(F1), 32'(prev_f1));
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got F0^F1=%0h expected no output", F0 ^ F1);
        end else begin
          e = sb.pop_front();
          chk("mono", 32'(F0 ^ F1), 32'(e.xm));
          chk("f1", 32'(F1), 32'(e.f1));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_f0 = F0;
      prev_f1 = F1;
    end
  endtask

  task automatic drive_item(input logic [3:0] ia, input logic [3:0] ib, input logic [18:0] ip,
                            input logic [14:0] exm, input logic [14:0] ef1);
    a = ia; b = ib; prng = ip;
    cur_exp = '{xm: exm, f1: ef1};
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n = 0;
    logic done = 1'b0;
    while (!done) begin
      @(negedge clk); #1;
      if (in_ready) done = 1'b1;
      else if (++n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        done = 1'b1;
      end
    end
    @(posedge clk); #2;
  endtask

  task automatic send_rand();
    logic [3:0]  ra, rb;
    logic [18:0] rp;
    ra = 4'($urandom); rb = 4'($urandom); rp = 19'($urandom);
    drive_item(ra, rb, rp, mono(ra ^ rb), rp[14:0] ^ mono(rb ^ rp[18:15]));
    wait_accept();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4'hA, 4'h5, 19'h00000, 15'h7FFF, 15'h0019};
    vecs[1] = '{4'h3, 4'h0, 19'h71234, 15'h0007, 15'h389E};
    vecs[2] = '{4'h0, 4'h0, 19'h00000, 15'h0000, 15'h0000};
    vecs[3] = '{4'hF, 4'hF, 19'h00000, 15'h0000, 15'h7FFF};
    vecs[4] = '{4'h1, 4'h0, 19'h00000, 15'h0001, 15'h0000};
    vecs[5] = '{4'h8, 4'h0, 19'h08000, 15'h0080, 15'h0001};
    vecs[6] = '{4'h6, 4'h3, 19'h00000, 15'h0019, 15'h0007};

    fork
      forever monitor_cycle();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_f0", 32'(F0), 32'd0);
    chk("rst_f1", 32'(F1), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;

    drive_item(vecs[0].a, vecs[0].b, vecs[0].prng, vecs[0].xm, vecs[0].f1);
    wait_accept();
    in_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      chk("latency_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #2;
    drain();

    for (int i = 0; i < 7; i++) begin
      drive_item(vecs[i].a, vecs[i].b, vecs[i].prng, vecs[i].xm, vecs[i].f1);
      wait_accept();
    end
    in_valid = 1'b0;
    drain();
    chk("table_count", 32'(out_count), 32'd8);

    do_reset();
    for (int i = 0; i < 1000; i++) send_rand();
    in_valid = 1'b0;
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      chk("stream_count", 32'(out_count), 32'(1000 - LAT + i));
    end
    chk("stream_wrap_count", 32'(w_count), 32'(1000 % 16));
    @(posedge clk); #2;
    drain();

    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) send_rand();
    drive_item(4'h9, 4'h6, 19'h2ABCD, mono(4'hF), 15'h2BCD ^ mono(4'h6 ^ 4'h5));
    for (int i = 0; i < 5 - LAT; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    drain();
    chk("bp_count", 32'(out_count), 32'(LAT + 1));

    do_reset();
    out_ready = 1'b0;
    send_rand();
    send_rand();
    in_valid = 1'b0;
    @(posedge clk); #2;
    do_reset();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #2;

    do_reset();
    for (int i = 0; i < 17; i++) send_rand();
    in_valid = 1'b0;
    drain();
    chk("wrap_count", 32'(w_count), 32'd1);
    chk("wide_count", 32'(out_count), 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
